median_filter_rx: RTL and testbench

Input-side line buffering for the median filter: slave video bus in, vertically aligned 3-row pixel columns out. It accepts the upstream pixel stream and keeps the two previous lines in circular line memories. For every accepted pixel it presents the pixel (bottom row) together with the pixels directly above it from the two preceding lines. It sits between the video source and the median core; the core's output side feeds the TX buffer.

---
 rtl/median_filter_pkg.sv | 25 ++
 rtl/median_filter_rx_if.sv | 13 +
 rtl/median_filter_line_mem.sv | 27 ++
 rtl/median_filter_rx.sv | 144 ++++++++++++++
 tb/tb_median_filter_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/median_filter_pkg.sv
// Shared types and constants for the median filter line-buffer front end.
package median_filter_pkg;

  localparam int unsigned DW_VD    = 14;
  localparam int unsigned DW_VX    = 4;
  localparam int unsigned MAX_IW   = 2048;
  localparam int unsigned AW       = $clog2(MAX_IW);
  localparam int unsigned IW_W     = 16;
  localparam int unsigned AUX_SOF  = 0;
  localparam int unsigned AUX_EOL  = 1;
  localparam int unsigned ROWS_MAX = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Last column index of a line: iw clipped to 1..MAX_IW, minus one.
  function automatic logic [AW-1:0] width_last(input logic [IW_W-1:0] iw);
    if (iw == '0) return '0;
    if (32'(iw) >= MAX_IW) return AW'(MAX_IW - 1);
    return AW'(iw - IW_W'(1));
  endfunction

endpackage

// File: rtl/median_filter_rx_if.sv
// Valid/ready video bus: pixel data plus aux sideband (SOF, EOL).
interface median_filter_rx_if #(
  parameter int unsigned DW_VD = median_filter_pkg::DW_VD,
  parameter int unsigned DW_VX = median_filter_pkg::DW_VX
);
  logic             val;
  logic             rdy;
  logic [DW_VX-1:0] aux;
  logic [DW_VD-1:0] dat;

  modport master (output val, aux, dat, input rdy);
  modport slave  (input val, aux, dat, output rdy);
endinterface

// File: rtl/median_filter_line_mem.sv
// Single-port line memory, synchronous read, read-before-write on a shared address.
module median_filter_line_mem import median_filter_pkg::*; #(
  parameter int unsigned DEPTH = MAX_IW,
  parameter int unsigned WIDTH = DW_VD
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdat,
  output logic [WIDTH-1:0]         rdat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdat;
  end

  // Read register is reset so the column outputs come up as zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)   rdat <= '0;
    else if (en) rdat <= mem[addr];
  end

endmodule

// File: rtl/median_filter_rx.sv
// Median filter input line buffer: pixel stream in, 3-row vertical columns out.
// Optional line-length checking is built when MEDIAN_FILTER_RX_LEN_CHECK_EN is defined.
module median_filter_rx import median_filter_pkg::*; (
  input  logic             clk,
  input  logic             rstb,
  median_filter_rx_if.slave s_vb,
  input  logic [IW_W-1:0]  iw,
  input  logic             lerr_clr,
  output logic             lerr,
  output logic             col_val,
  input  logic             col_rdy,
  output logic [DW_VX-1:0] col_aux,
  output logic [DW_VD-1:0] col_top,
  output logic [DW_VD-1:0] col_mid,
  output logic [DW_VD-1:0] col_bot,
  output logic [1:0]       col_rows
);

  state_e           state_q, state_d;
  logic [AW-1:0]    xcnt_q, xcnt_d, wlast_q, wlast_d, wlast_now, addr;
  logic [1:0]       rcnt_q, rcnt_d, rows_now;
  logic             par_q, par_d, sel_q, sel_d;
  logic             col_val_d, lerr_d;
  logic [DW_VX-1:0] col_aux_d;
  logic [DW_VD-1:0] col_bot_d, rdat0, rdat1;
  logic [1:0]       col_rows_d;
  logic             acc, sof, eol, proc, line_end;
`ifdef MEDIAN_FILTER_RX_LEN_CHECK_EN
  logic             lerr_set;
`else
  logic             unused_lerr_clr;
  assign unused_lerr_clr = lerr_clr;
`endif

  assign s_vb.rdy = (state_q == IDLE) || !col_val || col_rdy;
  assign acc      = s_vb.val && s_vb.rdy;
  assign sof      = s_vb.aux[AUX_SOF];
  assign eol      = s_vb.aux[AUX_EOL];

  // Next-state and datapath update for one accepted beat.
  always_comb begin
    state_d    = state_q;
    xcnt_d     = xcnt_q;
    rcnt_d     = rcnt_q;
    wlast_d    = wlast_q;
    par_d      = par_q;
    sel_d      = sel_q;
    col_val_d  = col_val;
    col_aux_d  = col_aux;
    col_bot_d  = col_bot;
    col_rows_d = col_rows;
    proc       = acc && ((state_q == ACTIVE) || sof);
    addr       = sof ? '0 : xcnt_q;
    rows_now   = sof ? 2'd0 : rcnt_q;
    wlast_now  = sof ? width_last(iw) : wlast_q;
    line_end   = eol || (addr == wlast_now);
`ifdef MEDIAN_FILTER_RX_LEN_CHECK_EN
    lerr_set   = 1'b0;
`endif

    if (col_rdy) col_val_d = 1'b0;

    if (proc) begin
      state_d    = ACTIVE;
      col_val_d  = 1'b1;
      col_aux_d  = s_vb.aux;
      col_bot_d  = s_vb.dat;
      col_rows_d = rows_now + 2'd1;
      sel_d      = par_q;
      wlast_d    = wlast_now;
      if (line_end) begin
        xcnt_d = '0;
        rcnt_d = (rows_now == 2'(ROWS_MAX - 1)) ? rows_now : rows_now + 2'd1;
        par_d  = ~par_q;
      end else begin
        xcnt_d = addr + AW'(1);
        rcnt_d = rows_now;
      end
`ifdef MEDIAN_FILTER_RX_LEN_CHECK_EN
      lerr_set = eol != (addr == wlast_now);
`endif
    end

`ifdef MEDIAN_FILTER_RX_LEN_CHECK_EN
    lerr_d = lerr_set ? 1'b1 : (lerr_clr ? 1'b0 : lerr);
`else
    lerr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      xcnt_q   <= '0;
      rcnt_q   <= '0;
      wlast_q  <= '0;
      par_q    <= 1'b0;
      sel_q    <= 1'b0;
      col_val  <= 1'b0;
      col_aux  <= '0;
      col_bot  <= '0;
      col_rows <= '0;
      lerr     <= 1'b0;
    end else begin
      state_q  <= state_d;
      xcnt_q   <= xcnt_d;
      rcnt_q   <= rcnt_d;
      wlast_q  <= wlast_d;
      par_q    <= par_d;
      sel_q    <= sel_d;
      col_val  <= col_val_d;
      col_aux  <= col_aux_d;
      col_bot  <= col_bot_d;
      col_rows <= col_rows_d;
      lerr     <= lerr_d;
    end
  end

  // Lines alternate between the two memories: the one being overwritten
  // always holds the line two rows up, the other holds the line just above.
  median_filter_line_mem #(.DEPTH(MAX_IW), .WIDTH(DW_VD)) mem0 (
    .clk  (clk),
    .rstb (rstb),
    .en   (proc),
    .we   (!par_q),
    .addr (addr),
    .wdat (s_vb.dat),
    .rdat (rdat0)
  );

  median_filter_line_mem #(.DEPTH(MAX_IW), .WIDTH(DW_VD)) mem1 (
    .clk  (clk),
    .rstb (rstb),
    .en   (proc),
    .we   (par_q),
    .addr (addr),
    .wdat (s_vb.dat),
    .rdat (rdat1)
  );

  assign col_top = sel_q ? rdat1 : rdat0;
  assign col_mid = sel_q ? rdat0 : rdat1;

endmodule

// File: tb/tb_median_filter_rx.sv
// Directed self-checking bench for median_filter_rx; honours MEDIAN_FILTER_RX_LEN_CHECK_EN.
module tb_median_filter_rx;
  import median_filter_pkg::*;

`ifdef MEDIAN_FILTER_RX_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  typedef struct {
    logic [13:0] top, mid, bot;
    logic [3:0]  aux;
    logic [1:0]  rows;
    bit          ct, cm;
  } col_t;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [15:0] iw = 16'd4;
  logic        lerr_clr = 1'b0;
  logic        lerr, col_val;
  logic        col_rdy = 1'b1;
  logic [3:0]  col_aux;
  logic [13:0] col_top, col_mid, col_bot;
  logic [1:0]  col_rows;
  bit          toggle_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  col_t        exp_q[$];

  median_filter_rx_if #(.DW_VD(14), .DW_VX(4)) vb ();

  median_filter_rx dut (
    .clk(clk), .rstb(rstb), .s_vb(vb), .iw(iw), .lerr_clr(lerr_clr), .lerr(lerr),
    .col_val(col_val), .col_rdy(col_rdy), .col_aux(col_aux), .col_top(col_top),
    .col_mid(col_mid), .col_bot(col_bot), .col_rows(col_rows)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_col(input int bot, input int aux, input int rows,
                            input int top, input int mid, input bit ct, input bit cm);
    col_t c;
    c.bot = 14'(bot); c.aux = 4'(aux); c.rows = 2'(rows);
    c.top = 14'(top); c.mid = 14'(mid); c.ct = ct; c.cm = cm;
    exp_q.push_back(c);
  endtask

  // One beat, held until accepted.
  task automatic send(input int d, input logic [3:0] x);
    int waits = 0;
    @(negedge clk);
    vb.val = 1'b1; vb.dat = 14'(d); vb.aux = x;
    #1;
    while (!vb.rdy && waits < 50) begin
      @(negedge clk); #1; waits++;
    end
    if (waits >= 50) check("send_timeout", 32'(waits), 0);
    @(posedge clk); #1;
    vb.val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk); #3;
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // 3 lines of width 4, pixel = 10*row+col.
  task automatic send_frame();
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < 4; x++) begin
        logic [3:0] a;
        a = {2'b00, x == 3, r == 0 && x == 0};
        expect_col(10*r + x, int'(a), r + 1, (r >= 2) ? 10*(r-2) + x : 0,
                   (r >= 1) ? 10*(r-1) + x : 0, r >= 2, r >= 1);
        send(10*r + x, a);
      end
  endtask

  // Column monitor: consumed columns against the expected queue, held fields while stalled.
  initial begin
    bit          stalled = 1'b0;
    logic [13:0] s_top, s_mid, s_bot;
    logic [1:0]  s_rows;
    col_t        e;
    forever begin
      @(negedge clk); #2;
      if (!rstb) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_top", 32'(col_top), 32'(s_top));
          check("hold_mid", 32'(col_mid), 32'(s_mid));
          check("hold_bot", 32'(col_bot), 32'(s_bot));
          check("hold_rows", 32'(col_rows), 32'(s_rows));
        end
        stalled = col_val && !col_rdy;
        s_top = col_top; s_mid = col_mid; s_bot = col_bot; s_rows = col_rows;
        if (col_val && col_rdy) begin
          if (exp_q.size() == 0) begin
            check("col_extra", 32'(col_bot), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("col_rows", 32'(col_rows), 32'(e.rows));
            check("col_bot", 32'(col_bot), 32'(e.bot));
            check("col_aux", 32'(col_aux), 32'(e.aux));
            if (e.cm) check("col_mid", 32'(col_mid), 32'(e.mid));
            if (e.ct) check("col_top", 32'(col_top), 32'(e.top));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (toggle_en) col_rdy = ~col_rdy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vb.val = 1'b0; vb.dat = '0; vb.aux = '0;
    #1;
    check("rst_col_val", 32'(col_val), 0);
    check("rst_col_rows", 32'(col_rows), 0);
    check("rst_col_bot", 32'(col_bot), 0);
    check("rst_col_top", 32'(col_top), 0);
    check("rst_col_mid", 32'(col_mid), 0);
    check("rst_col_aux", 32'(col_aux), 0);
    check("rst_lerr", 32'(lerr), 0);
    check("rst_rdy", 32'(vb.rdy), 1);
    repeat (3) @(negedge clk);
    rstb = 1'b1;

    // Beats before the first SOF are dropped.
    for (int i = 0; i < 3; i++) begin
      send(50 + i, 4'b0000);
      check("idle_col_val", 32'(col_val), 0);
      check("idle_rdy", 32'(vb.rdy), 1);
    end

    iw = 16'd4;
    send_frame();
    drain();
    check("frame_lerr", 32'(lerr), 0);

    // Same frame with a 1/0 ready pattern.
    toggle_en = 1'b1;
    send_frame();
    drain();
    toggle_en = 1'b0;
    @(negedge clk); #1;
    col_rdy = 1'b1;

    // Short line: EOL on the third pixel.
    expect_col(70, 1, 1, 0, 0, 0, 0); send(70, 4'b0001);
    expect_col(71, 0, 1, 0, 0, 0, 0); send(71, 4'b0000);
    expect_col(72, 2, 1, 0, 0, 0, 0); send(72, 4'b0010);
    drain();
    check("short_lerr", 32'(lerr), 32'(LEN_CHK));
    @(negedge clk); lerr_clr = 1'b1;
    @(posedge clk); #1; lerr_clr = 1'b0;
    check("lerr_clr", 32'(lerr), 0);

    // No EOL: forced wrap after the fourth pixel.
    for (int i = 0; i < 6; i++) begin
      expect_col(100 + i, (i == 0) ? 1 : 0, (i < 4) ? 1 : 2, 0, (i >= 4) ? 100 + i - 4 : 0, 0, i >= 4);
      send(100 + i, (i == 0) ? 4'b0001 : 4'b0000);
    end
    drain();
    check("wrap_lerr", 32'(lerr), 32'(LEN_CHK));

    // SOF mid-line restarts the frame.
    for (int x = 0; x < 4; x++) begin
      expect_col(200 + x, (x == 0) ? 1 : ((x == 3) ? 2 : 0), 1, 0, 0, 0, 0);
      send(200 + x, (x == 0) ? 4'b0001 : ((x == 3) ? 4'b0010 : 4'b0000));
    end
    expect_col(210, 0, 2, 0, 200, 0, 1); send(210, 4'b0000);
    expect_col(211, 0, 2, 0, 201, 0, 1); send(211, 4'b0000);
    expect_col(300, 1, 1, 0, 0, 0, 0); send(300, 4'b0001);
    expect_col(301, 0, 1, 0, 0, 0, 0); send(301, 4'b0000);
    drain();

    // Reset mid-frame.
    @(negedge clk); rstb = 1'b0;
    #1;
    check("mrst_col_val", 32'(col_val), 0);
    check("mrst_col_bot", 32'(col_bot), 0);
    check("mrst_col_top", 32'(col_top), 0);
    check("mrst_col_mid", 32'(col_mid), 0);
    check("mrst_col_rows", 32'(col_rows), 0);
    check("mrst_col_aux", 32'(col_aux), 0);
    check("mrst_lerr", 32'(lerr), 0);
    check("mrst_rdy", 32'(vb.rdy), 1);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    send(400, 4'b0000);
    check("post_rst_drop0", 32'(col_val), 0);
    send(401, 4'b0000);
    check("post_rst_drop1", 32'(col_val), 0);
    expect_col(7, 1, 1, 0, 0, 0, 0);
    send(7, 4'b0001);
    check("post_rst_sof_val", 32'(col_val), 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
